// File: rtl/softmax_pkg.sv
// Shared fp16 helpers, FSM state type and default geometry for the softmax
// row-max prepass and the downstream exp stage.
package softmax_pkg;

    localparam int DAT_DW_DEF = 16;
    localparam int TOUT_DEF   = 8;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN
    } state_t;

    // Maps fp16 onto an unsigned total order: -inf lowest, -0 below +0,
    // NaNs land past the infinities according to their bit pattern.
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
        return (fp16_key(b) > fp16_key(a)) ? b : a;
    endfunction

endpackage

// File: rtl/softmax_lane_max.sv
// Combinational fp16 max tree over one beat; lanes with mask=0 count as -inf.
module softmax_lane_max
    import softmax_pkg::*;
#(
    parameter int DAT_DW = DAT_DW_DEF,
    parameter int TOUT   = TOUT_DEF
) (
    input  logic [TOUT*DAT_DW-1:0] data,
    input  logic [TOUT-1:0]        mask,
    output logic [DAT_DW-1:0]      max_val
);

    // Heap-ordered tree padded to a power of two; leaves start at NP-1.
    localparam int NP = (TOUT > 1) ? (1 << $clog2(TOUT)) : 1;

    logic [DAT_DW-1:0] node [2*NP-1];

    always_comb begin
        for (int i = 0; i < 2*NP-1; i++) begin
            node[i] = FP16_NEG_INF;
        end
        for (int i = 0; i < TOUT; i++) begin
            if (mask[i]) begin
                node[NP-1+i] = data[i*DAT_DW +: DAT_DW];
            end
        end
        for (int k = NP-2; k >= 0; k--) begin
            node[k] = fp16_max(node[2*k+1], node[2*k+2]);
        end
        max_val = node[0];
    end

endmodule

// File: rtl/softmax_row_max.sv
// Row-maximum prepass: buffers one softmax row, then replays it with the row
// max attached. Define SOFTMAX_ROWMAX_MASK_EN to mask padding lanes of the last beat.
module softmax_row_max
    import softmax_pkg::*;
#(
    parameter int DAT_DW        = DAT_DW_DEF,
    parameter int TOUT          = TOUT_DEF,
    parameter int MAX_ROW_BEATS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0]                 cfg_rows,
    input  logic [7:0]                  cfg_row_beats,
    input  logic [$clog2(TOUT+1)-1:0]   cfg_last_lanes,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [TOUT*DAT_DW-1:0]      s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [TOUT*DAT_DW-1:0]      m_data,
    output logic [DAT_DW-1:0]           m_max,
    output logic                        m_last
);

    localparam int AW = (MAX_ROW_BEATS > 1) ? $clog2(MAX_ROW_BEATS) : 1;
    localparam int BW = TOUT * DAT_DW;

    state_t            state, state_nxt;
    logic [15:0]       rows_r, row_cnt;
    logic [7:0]        row_beats_r, beat_cnt, rd_cnt, rd_nxt;
    logic [DAT_DW-1:0] max_r, beat_max, max_nxt;
    logic [BW-1:0]     buffer [MAX_ROW_BEATS];
    logic [BW-1:0]     wr_data;
    logic [TOUT-1:0]   lane_mask;
    logic              cfg_ok, last_beat, fill_hs, fill_end, drain_hs, row_end, job_end;
`ifdef SOFTMAX_ROWMAX_MASK_EN
    logic [$clog2(TOUT+1)-1:0] last_lanes_r;
`endif

    always_comb begin
        cfg_ok    = (cfg_row_beats != 8'd0) && (int'(cfg_row_beats) <= MAX_ROW_BEATS) &&
                    (cfg_last_lanes != '0) && (int'(cfg_last_lanes) <= TOUT);
        last_beat = (beat_cnt == row_beats_r - 8'd1);
        fill_hs   = (state == ST_FILL) && s_valid;
        fill_end  = fill_hs && last_beat;
        drain_hs  = m_valid && m_ready;
        row_end   = drain_hs && m_last;
        job_end   = row_end && (row_cnt == rows_r - 16'd1);
        rd_nxt    = rd_cnt + 8'd1;
        max_nxt   = fp16_max(max_r, beat_max);
    end

    // Padding lanes of the last beat are dropped from the max and stored as -inf.
    always_comb begin
        lane_mask = '1;
        wr_data   = s_data;
`ifdef SOFTMAX_ROWMAX_MASK_EN
        for (int i = 0; i < TOUT; i++) begin
            if (last_beat && (i >= int'(last_lanes_r))) begin
                lane_mask[i]                 = 1'b0;
                wr_data[i*DAT_DW +: DAT_DW]  = FP16_NEG_INF;
            end
        end
`endif
    end

    softmax_lane_max #(
        .DAT_DW (DAT_DW),
        .TOUT   (TOUT)
    ) u_lane_max (
        .data    (s_data),
        .mask    (lane_mask),
        .max_val (beat_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        s_ready   = (state == ST_FILL);
        case (state)
            ST_IDLE:  if (start && cfg_ok && (cfg_rows != 16'd0)) state_nxt = ST_FILL;
            ST_FILL:  if (fill_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (row_end) state_nxt = job_end ? ST_IDLE : ST_FILL;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Register array with combinational read; contents need no reset.
    always_ff @(posedge clk) begin
        if (fill_hs) begin
            buffer[beat_cnt[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            rows_r       <= '0;
            row_beats_r  <= '0;
            row_cnt      <= '0;
            beat_cnt     <= '0;
            rd_cnt       <= '0;
            max_r        <= FP16_NEG_INF;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_max        <= '0;
            m_last       <= 1'b0;
`ifdef SOFTMAX_ROWMAX_MASK_EN
            last_lanes_r <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!cfg_ok) begin
                            cfg_err <= 1'b1;
                        end else if (cfg_rows == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            rows_r       <= cfg_rows;
                            row_beats_r  <= cfg_row_beats;
                            row_cnt      <= '0;
                            beat_cnt     <= '0;
                            max_r        <= FP16_NEG_INF;
`ifdef SOFTMAX_ROWMAX_MASK_EN
                            last_lanes_r <= cfg_last_lanes;
`endif
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_hs) begin
                        max_r <= max_nxt;
                        if (fill_end) begin
                            // A one-beat row bypasses the buffer write happening this cycle.
                            beat_cnt <= '0;
                            rd_cnt   <= '0;
                            m_valid  <= 1'b1;
                            m_max    <= max_nxt;
                            m_last   <= (row_beats_r == 8'd1);
                            m_data   <= (row_beats_r == 8'd1) ? wr_data : buffer[AW'(0)];
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_hs) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            if (job_end) begin
                                done <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 16'd1;
                                max_r   <= FP16_NEG_INF;
                            end
                        end else begin
                            rd_cnt <= rd_nxt;
                            m_data <= buffer[rd_nxt[AW-1:0]];
                            m_last <= (rd_nxt == row_beats_r - 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_max.sv
// Directed bench for softmax_row_max with hand-computed fp16 row maxima.
module tb_softmax_row_max;

    localparam int DW = 16;
    localparam int TO = 8;
    localparam int BW = DW * TO;
`ifdef SOFTMAX_ROWMAX_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   cfg_rows;
    logic [7:0]    cfg_row_beats;
    logic [3:0]    cfg_last_lanes;
    logic          busy, done, cfg_err;
    logic          s_valid, s_ready;
    logic [BW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [BW-1:0] m_data;
    logic [DW-1:0] m_max;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] vec [8];

    softmax_row_max #(
        .DAT_DW        (DW),
        .TOUT          (TO),
        .MAX_ROW_BEATS (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_rows       (cfg_rows),
        .cfg_row_beats  (cfg_row_beats),
        .cfg_last_lanes (cfg_last_lanes),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_max          (m_max),
        .m_last         (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2, input logic [15:0] l3,
                                         input logic [15:0] l4, input logic [15:0] l5,
                                         input logic [15:0] l6, input logic [15:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int b, input int n, input int ll);
        logic [BW-1:0] v;
        v = vec[b];
        if (MASK_EN && (b == n-1)) begin
            for (int i = ll; i < TO; i++) v[i*DW +: DW] = 16'hFC00;
        end
        return v;
    endfunction

    task automatic do_start(input logic [15:0] rows, input logic [7:0] beats, input logic [3:0] lanes);
        start          = 1'b1;
        cfg_rows       = rows;
        cfg_row_beats  = beats;
        cfg_last_lanes = lanes;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_row(input int n);
        int w;
        for (int b = 0; b < n; b++) begin
            s_valid = 1'b1;
            s_data  = vec[b];
            w = 0;
            while (!s_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!s_ready) begin
                check("s_ready_wait", BW'(s_ready), BW'(1));
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic drain_row(input int n, input int ll, input logic [15:0] xmax, input bit bp,
                             input string tag);
        int b, cyc;
        bit stalled, tog;
        logic [BW-1:0] hd;
        logic [15:0]   hm;
        logic          hl;
        b = 0; cyc = 0; stalled = 1'b0; tog = 1'b0;
        hd = '0; hm = '0; hl = 1'b0;
        while (b < n && cyc < 300) begin
            m_ready = bp ? tog : 1'b1;
            tog = ~tog;
            if (m_valid) begin
                if (stalled) begin
                    check({tag, "_hold_data"}, m_data, hd);
                    check({tag, "_hold_max"}, BW'(m_max), BW'(hm));
                    check({tag, "_hold_last"}, BW'(m_last), BW'(hl));
                end
                check({tag, "_s_ready_drain"}, BW'(s_ready), BW'(0));
                if (m_ready) begin
                    check({tag, "_data"}, m_data, exp_beat(b, n, ll));
                    check({tag, "_max"}, BW'(m_max), BW'(xmax));
                    check({tag, "_last"}, BW'(m_last), BW'(b == n-1));
                    b++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = m_data; hm = m_max; hl = m_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (b < n) check({tag, "_drain_timeout"}, BW'(b), BW'(n));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_row_beats = '0; cfg_last_lanes = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_done", BW'(done), BW'(0));
        check("rst_cfg_err", BW'(cfg_err), BW'(0));
        check("rst_s_ready", BW'(s_ready), BW'(0));
        check("rst_m_valid", BW'(m_valid), BW'(0));
        check("rst_m_last", BW'(m_last), BW'(0));
        check("rst_m_data", m_data, BW'(0));
        check("rst_m_max", BW'(m_max), BW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic row: 5.0 hidden in beat 1, padding already -inf.
        vec[0] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        vec[1] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00, 16'h3C00);
        vec[2] = mk(16'h4000, 16'h3C00, 16'h3800, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00);
        do_start(16'd1, 8'd3, 4'd3);
        check("t1_busy", BW'(busy), BW'(1));
        check("t1_s_ready", BW'(s_ready), BW'(1));
        feed_row(3);
        check("t1_first_valid", BW'(m_valid), BW'(1));
        drain_row(3, 3, 16'h4500, 1'b0, "t1");
        check("t1_done", BW'(done), BW'(1));
        check("t1_busy_low", BW'(busy), BW'(0));
        @(negedge clk);
        check("t1_done_pulse", BW'(done), BW'(0));

        // Padding lanes hold 32768.0; only the masked build ignores them.
        vec[0] = mk(16'h3C00, 16'h3800, 16'h3C00, 16'h3800, 16'h3C00, 16'h3800, 16'h3C00, 16'h3800);
        vec[1] = mk(16'h4000, 16'h3C00, 16'hB800, 16'h7800, 16'h7800, 16'h7800, 16'h7800, 16'h7800);
        do_start(16'd1, 8'd2, 4'd3);
        feed_row(2);
        drain_row(2, 3, MASK_EN ? 16'h4000 : 16'h7800, 1'b0, "t2");
        check("t2_done", BW'(done), BW'(1));
        @(negedge clk);

        // Sign handling, one-beat rows: all negative, +0 vs -0, -0 vs -0.5.
        do_start(16'd3, 8'd1, 4'd8);
        vec[0] = mk(16'hC200, 16'hB800, 16'hC000, 16'hC400, 16'hBC00, 16'hC200, 16'hC500, 16'hB900);
        feed_row(1);
        check("t3_first_valid", BW'(m_valid), BW'(1));
        drain_row(1, 8, 16'hB800, 1'b0, "t3a");
        check("t3a_s_ready_back", BW'(s_ready), BW'(1));
        vec[0] = mk(16'h8000, 16'hB800, 16'hC000, 16'hFC00, 16'h8000, 16'h0000, 16'hC200, 16'hBC00);
        feed_row(1);
        drain_row(1, 8, 16'h0000, 1'b0, "t3b");
        vec[0] = mk(16'hC200, 16'hB800, 16'h8000, 16'hC000, 16'hFC00, 16'hFC00, 16'hC400, 16'hBC00);
        feed_row(1);
        drain_row(1, 8, 16'h8000, 1'b0, "t3c");
        check("t3_done", BW'(done), BW'(1));
        @(negedge clk);

        // Backpressure over two 4-beat rows; row 2 max far below row 1.
        do_start(16'd2, 8'd4, 4'd8);
        vec[0] = mk(16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'h4400, 16'h3C00, 16'hC000, 16'h3C00);
        vec[1] = mk(16'h4800, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        vec[2] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h4C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        vec[3] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h5000);
        feed_row(4);
        drain_row(4, 8, 16'h5000, 1'b1, "t4a");
        check("t4_s_ready_back", BW'(s_ready), BW'(1));
        vec[0] = mk(16'h3800, 16'h3400, 16'h3E00, 16'hB800, 16'h3000, 16'h3800, 16'h3400, 16'h0000);
        vec[1] = mk(16'hBC00, 16'h3C00, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800);
        vec[2] = mk(16'h3A00, 16'h3A00, 16'hC000, 16'h3A00, 16'h3A00, 16'h3A00, 16'h3A00, 16'h3A00);
        vec[3] = mk(16'h3C00, 16'h3D00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        feed_row(4);
        drain_row(4, 8, 16'h3E00, 1'b1, "t4b");
        check("t4_done", BW'(done), BW'(1));
        @(negedge clk);

        // Config errors and the empty job.
        do_start(16'd1, 8'd0, 4'd8);
        check("t5_err_beats0", BW'(cfg_err), BW'(1));
        check("t5_busy_beats0", BW'(busy), BW'(0));
        @(negedge clk);
        check("t5_err_pulse", BW'(cfg_err), BW'(0));
        do_start(16'd1, 8'd65, 4'd8);
        check("t5_err_beats65", BW'(cfg_err), BW'(1));
        check("t5_busy_beats65", BW'(busy), BW'(0));
        @(negedge clk);
        do_start(16'd1, 8'd4, 4'd9);
        check("t5_err_lanes9", BW'(cfg_err), BW'(1));
        @(negedge clk);
        do_start(16'd0, 8'd4, 4'd8);
        check("t5_rows0_done", BW'(done), BW'(1));
        check("t5_rows0_busy", BW'(busy), BW'(0));
        check("t5_rows0_err", BW'(cfg_err), BW'(0));
        @(negedge clk);
        check("t5_rows0_pulse", BW'(done), BW'(0));

        // Reset in the middle of draining row 1 of 2.
        do_start(16'd2, 8'd2, 4'd8);
        vec[0] = mk(16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400);
        vec[1] = mk(16'h4600, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400, 16'h4400);
        feed_row(2);
        m_ready = 1'b0;
        @(negedge clk);
        check("t6_pre_valid", BW'(m_valid), BW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", BW'(m_valid), BW'(0));
        check("t6_rst_m_data", m_data, BW'(0));
        check("t6_rst_m_max", BW'(m_max), BW'(0));
        check("t6_rst_m_last", BW'(m_last), BW'(0));
        check("t6_rst_busy", BW'(busy), BW'(0));
        check("t6_rst_s_ready", BW'(s_ready), BW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_done", BW'(done), BW'(0));
        do_start(16'd1, 8'd1, 4'd8);
        vec[0] = mk(16'h3C00, 16'hC800, 16'h4800, 16'h4700, 16'h0000, 16'h8000, 16'hFC00, 16'h3C00);
        feed_row(1);
        drain_row(1, 8, 16'h4800, 1'b0, "t6");
        check("t6_done", BW'(done), BW'(1));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
